// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save accumulating adder: tree sizing and operand extension.
package csa_pkg;

  // Widest operand/result the extension helper can handle.
  localparam int EXT_MAX_W = 128;

  // Number of live values left after lvl levels of 3:2 reduction, starting from n.
  function automatic int csa_count(input int n, input int lvl);
    int k;
    k = n;
    for (int i = 0; i < lvl; i++) begin
      k = k - k / 3;
    end
    return k;
  endfunction

  // Number of 3:2 levels needed to bring n values down to a pair.
  function automatic int csa_levels(input int n);
    int k;
    int l;
    k = n;
    l = 0;
    while (k > 2) begin
      k = k - k / 3;
      l++;
    end
    return l;
  endfunction

  // Extend the low w bits of op to EXT_MAX_W, replicating bit w-1 when sgn is set.
  function automatic logic [EXT_MAX_W-1:0] ext(input logic [EXT_MAX_W-1:0] op, input int w,
                                               input bit sgn);
    logic [EXT_MAX_W-1:0] r;
    r = op;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i >= w) r[i] = sgn & op[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_tree.sv
// Combinational N-input carry-save (Wallace) reduction down to a sum/carry pair.
// Each level compresses floor(k/3) triples with full adders and passes the rest through.
module csa_tree
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 3
) (
  input  logic [N*WIDTH-1:0] in_flat,
  output logic [WIDTH-1:0]   s,
  output logic [WIDTH-1:0]   c
);

  localparam int LEVELS = csa_levels(N);

  // node[l][j]: j-th live value entering level l; slots beyond the live count are tied to zero.
  logic [WIDTH-1:0] node [LEVELS+1][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_in
    assign node[0][gi] = in_flat[gi*WIDTH +: WIDTH];
  end

  for (genvar gl = 0; gl < LEVELS; gl++) begin : g_lvl
    localparam int K = csa_count(N, gl);
    localparam int G = K / 3;

    // Full-adder groups: sum stays in place, carry moves up one bit and the top carry is dropped.
    for (genvar gi = 0; gi < G; gi++) begin : g_fa
      assign node[gl+1][2*gi]   = node[gl][3*gi] ^ node[gl][3*gi+1] ^ node[gl][3*gi+2];
      assign node[gl+1][2*gi+1] = ((node[gl][3*gi]   & node[gl][3*gi+1]) |
                                   (node[gl][3*gi]   & node[gl][3*gi+2]) |
                                   (node[gl][3*gi+1] & node[gl][3*gi+2])) << 1;
    end

    for (genvar gi = 0; gi < K - 3*G; gi++) begin : g_pass
      assign node[gl+1][2*G+gi] = node[gl][3*G+gi];
    end

    for (genvar gi = K - G; gi < N; gi++) begin : g_zero
      assign node[gl+1][gi] = '0;
    end
  end

  assign s = node[LEVELS][0];
  assign c = node[LEVELS][1];

endmodule

// File: rtl/csa_accum_adder.sv
// Two-stage multi-operand adder: carry-save compression with an optional running
// accumulator kept in sum/carry form, followed by a single carry-propagate add.
module csa_accum_adder
  import csa_pkg::*;
#(
  parameter int W       = 16,
  parameter int NUM_OPS = 3,
  parameter int ACC_W   = W + $clog2(NUM_OPS) + 8,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IN_valid,
  output logic               OUT_inReady,
  input  logic [NUM_OPS*W-1:0] IN_ops,
  input  logic               IN_acc,
  output logic               OUT_valid,
  input  logic               IN_outReady,
  output logic [ACC_W-1:0]   OUT_sum
);

  typedef struct packed {
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] c;
  } cs_pair_t;

  localparam int TREE_N = NUM_OPS + 2;

  logic             s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0] s1_s_q, s1_s_d;
  logic [ACC_W-1:0] s1_c_q, s1_c_d;
  logic             s2_valid_q, s2_valid_d;
  logic [ACC_W-1:0] s2_sum_q, s2_sum_d;
  logic [ACC_W-1:0] acc_s_q, acc_s_d;
  logic [ACC_W-1:0] acc_c_q, acc_c_d;

  logic                    s1_adv, s2_adv, accept;
  logic [TREE_N*ACC_W-1:0] tree_in;
  logic [ACC_W-1:0]        tree_s, tree_c;
  cs_pair_t                beat_pair;

  // Operands widened to the full internal width before compression so no carry is lost.
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_ext
    assign tree_in[gi*ACC_W +: ACC_W] =
      ACC_W'(ext(EXT_MAX_W'(IN_ops[gi*W +: W]), W, SIGNED != 0));
  end

  // Accumulator pair joins the tree only when the beat asks to accumulate.
  assign tree_in[NUM_OPS*ACC_W +: ACC_W]     = IN_acc ? acc_s_q : '0;
  assign tree_in[(NUM_OPS+1)*ACC_W +: ACC_W] = IN_acc ? acc_c_q : '0;

  csa_tree #(
    .WIDTH(ACC_W),
    .N    (TREE_N)
  ) u_tree (
    .in_flat(tree_in),
    .s      (tree_s),
    .c      (tree_c)
  );

  // With two operands and no accumulation the operands already form a carry-save pair.
  if (NUM_OPS == 2) begin : g_bypass
    assign beat_pair = IN_acc ? cs_pair_t'{s: tree_s, c: tree_c}
                              : cs_pair_t'{s: tree_in[0 +: ACC_W], c: tree_in[ACC_W +: ACC_W]};
  end else begin : g_tree
    assign beat_pair = cs_pair_t'{s: tree_s, c: tree_c};
  end

  // Whole-pipeline stall: each stage moves when the stage ahead is empty or moving.
  always_comb begin
    s2_adv      = !s2_valid_q || IN_outReady;
    s1_adv      = !s1_valid_q || s2_adv;
    OUT_inReady = s1_adv;
    accept      = IN_valid && s1_adv;
  end

  // Next-state for both stages and the accumulator pair.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_s_d     = s1_s_q;
    s1_c_d     = s1_c_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    acc_s_d    = acc_s_q;
    acc_c_d    = acc_c_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_sum_d = s1_s_q + s1_c_q;
    end
    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_s_d  = beat_pair.s;
      s1_c_d  = beat_pair.c;
      acc_s_d = beat_pair.s;
      acc_c_d = beat_pair.c;
    end
  end

  // Pipeline and accumulator registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= '0;
      s1_c_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      acc_s_q    <= '0;
      acc_c_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_s_q     <= s1_s_d;
      s1_c_q     <= s1_c_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      acc_s_q    <= acc_s_d;
      acc_c_q    <= acc_c_d;
    end
  end

  assign OUT_valid = s2_valid_q;
  assign OUT_sum   = s2_sum_q;

endmodule

// File: tb/tb_csa_accum_adder.sv
// Bench for csa_accum_adder: an unsigned 3-operand and a signed 5-operand instance
// share handshake stimulus and are checked every cycle against a queue-based model.
module tb_csa_accum_adder;

  localparam int W     = 8;
  localparam int ACC_W = 10;
  localparam int NA    = 3;
  localparam int NB    = 5;
  localparam int MASK  = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_acc, out_ready;
  logic [W-1:0]     op [NB];
  logic [NA*W-1:0]  ops_a;
  logic [NB*W-1:0]  ops_b;
  logic             rdy_a, vld_a, rdy_b, vld_b;
  logic [ACC_W-1:0] sum_a, sum_b;

  always_comb begin
    ops_a = '0;
    ops_b = '0;
    for (int i = 0; i < NA; i++) ops_a[i*W +: W] = op[i];
    for (int i = 0; i < NB; i++) ops_b[i*W +: W] = op[i];
  end

  csa_accum_adder #(.W(W), .NUM_OPS(NA), .ACC_W(ACC_W), .SIGNED(0)) u_dut_a (
    .clk(clk), .rst(rst), .IN_valid(in_valid), .OUT_inReady(rdy_a), .IN_ops(ops_a),
    .IN_acc(in_acc), .OUT_valid(vld_a), .IN_outReady(out_ready), .OUT_sum(sum_a));

  csa_accum_adder #(.W(W), .NUM_OPS(NB), .ACC_W(ACC_W), .SIGNED(1)) u_dut_b (
    .clk(clk), .rst(rst), .IN_valid(in_valid), .OUT_inReady(rdy_b), .IN_ops(ops_b),
    .IN_acc(in_acc), .OUT_valid(vld_b), .IN_outReady(out_ready), .OUT_sum(sum_b));

  // Reference model: in-flight results with the stage each one occupies.
  typedef struct {
    int unsigned a;
    int unsigned b;
    int          stage;
  } item_t;

  item_t       pq[$];
  int unsigned acc_a, acc_b;
  int unsigned got_a[$], got_b[$];
  bit          last_acc;
  int          n_pass, n_checks;

  function automatic int unsigned beat_a();
    int unsigned s;
    s = in_acc ? acc_a : 0;
    for (int i = 0; i < NA; i++) s += op[i];
    return s & MASK;
  endfunction

  function automatic int unsigned beat_b();
    int s;
    s = in_acc ? int'(acc_b) : 0;
    for (int i = 0; i < NB; i++) s += int'($signed(op[i]));
    return int'(s) & MASK;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: compare outputs against the model, then advance both across the edge.
  task automatic cycle();
    bit          m_ready, m_valid, acc_now, cons;
    int unsigned nsa, nsb;
    item_t       it;
    #1;
    m_ready = (pq.size() < 2) || out_ready;
    m_valid = (pq.size() > 0) && (pq[0].stage == 2);
    check("ready_a", rdy_a, m_ready);
    check("ready_b", rdy_b, m_ready);
    check("valid_a", vld_a, m_valid);
    check("valid_b", vld_b, m_valid);
    if (m_valid) begin
      check("sum_a", sum_a, pq[0].a);
      check("sum_b", sum_b, pq[0].b);
    end
    acc_now = in_valid && m_ready && !rst;
    cons    = m_valid && out_ready && !rst;
    nsa     = beat_a();
    nsb     = beat_b();
    @(posedge clk);
    if (rst) begin
      pq.delete();
      acc_a = 0;
      acc_b = 0;
    end else begin
      if (cons) begin
        got_a.push_back(pq[0].a);
        got_b.push_back(pq[0].b);
        void'(pq.pop_front());
      end
      if (pq.size() > 0 && pq[0].stage == 1) pq[0].stage = 2;
      if (acc_now) begin
        it.a = nsa;
        it.b = nsb;
        it.stage = 1;
        pq.push_back(it);
        acc_a = nsa;
        acc_b = nsb;
      end
    end
    last_acc = acc_now;
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic acc);
    op[0] = a0; op[1] = a1; op[2] = a2; op[3] = '0; op[4] = '0;
    in_acc = acc;
  endtask

  task automatic send(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic acc);
    load(a0, a1, a2, acc);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_acc) break;
    end
    check("send_accepted", last_acc, 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (pq.size() == 0) break;
      cycle();
    end
    #1;
    check("drain_valid_a", vld_a, 0);
  endtask

  initial begin
    int n;
    n_pass = 0; n_checks = 0; last_acc = 0;
    acc_a = 0; acc_b = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    load(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("reset_valid_a", vld_a, 0);
    check("reset_sum_a", sum_a, 0);
    check("reset_valid_b", vld_b, 0);
    check("reset_sum_b", sum_b, 0);
    rst = 1'b0;
    #1;
    check("reset_ready_a", rdy_a, 1);

    // Wide result: 128+128 is not truncated to 8 bits, visible two cycles after accept.
    send(8'd128, 8'd128, 8'd0, 1'b0);
    in_valid = 1'b0;
    cycle();
    #1;
    check("t1_valid", vld_a, 1);
    check("t1_sum", sum_a, 256);
    drain();

    // Back-to-back accumulation with no bubbles.
    got_a.delete();
    send(8'd1, 8'd2, 8'd3, 1'b0);
    send(8'd10, 8'd10, 8'd10, 1'b1);
    send(8'd5, 8'd0, 8'd0, 1'b1);
    drain();
    check("t2_r0", got_a[0], 6);
    check("t2_r1", got_a[1], 36);
    check("t2_r2", got_a[2], 41);

    // Backpressure: only two beats fit while the consumer stalls, then all four drain in order.
    got_a.delete();
    out_ready = 1'b0;
    n = 0;
    load(8'd1, 8'd1, 8'd1, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (last_acc) begin
        n++;
        case (n)
          1: load(8'd2, 8'd2, 8'd2, 1'b0);
          2: load(8'd3, 8'd0, 8'd0, 1'b1);
          3: load(8'd4, 8'd0, 8'd0, 1'b1);
          default: in_valid = 1'b0;
        endcase
      end
    end
    #1;
    check("t3_accepted", n, 2);
    check("t3_ready_low", rdy_a, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && n < 4; k++) begin
      cycle();
      if (last_acc) begin
        n++;
        if (n == 3) load(8'd4, 8'd0, 8'd0, 1'b1);
        else in_valid = 1'b0;
      end
    end
    drain();
    check("t3_r0", got_a[0], 3);
    check("t3_r1", got_a[1], 6);
    check("t3_r2", got_a[2], 9);
    check("t3_r3", got_a[3], 13);

    // Signed extension and modulo-2^ACC_W wrap of the accumulator.
    got_a.delete(); got_b.delete();
    send(8'hFF, 8'hFF, 8'h7F, 1'b0);
    drain();
    check("t4_signed", got_b[0], 125);
    got_a.delete();
    send(8'd255, 8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd3, 8'd0, 1'b1);
    send(8'd1, 8'd0, 8'd0, 1'b1);
    drain();
    check("t4_full", got_a[1], 1023);
    check("t4_wrap", got_a[2], 0);

    // Reset with both stages full discards them and clears the accumulator.
    out_ready = 1'b0;
    send(8'd7, 8'd7, 8'd7, 1'b0);
    send(8'd9, 8'd9, 8'd9, 1'b1);
    in_valid = 1'b0;
    #1;
    check("t5_full_ready", rdy_a, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("t5_valid", vld_a, 0);
    out_ready = 1'b1;
    got_a.delete();
    send(8'd5, 8'd6, 8'd7, 1'b1);
    drain();
    check("t5_fresh", got_a[0], 18);

    // Random traffic with random valid/ready; payload only changes when allowed.
    for (int k = 0; k < 600; k++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(3) != 0);
        for (int i = 0; i < NB; i++) op[i] = W'($urandom);
        in_acc = $urandom_range(1);
      end
      out_ready = ($urandom_range(2) != 0);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
